processed_data_sink: RTL and testbench

// - Downstream consumer of fpga_module's processed_data/error_flag stream.
// - Buffers tagged 32-bit words in a synchronous FIFO and presents them on a valid/ready port.
// - Counts error-flagged words and records overflow for the host-side reader.

---
 rtl/fpga_pkg.sv | 12 +
 rtl/sink_fifo_mem.sv | 28 ++
 rtl/processed_data_sink.sv | 134 +++++++++++++
 tb/tb_processed_data_sink.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_pkg.sv
// rtl/fpga_pkg.sv - shared widths and state type for the processed data sink
package fpga_pkg;

  localparam int SINK_DATA_W   = 32;
  localparam int SINK_ERRCNT_W = 16;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sink_state_t;

endpackage

// File: rtl/sink_fifo_mem.sv
// rtl/sink_fifo_mem.sv - DEPTH x (DATA_W+1) storage array, one write port, async read
module sink_fifo_mem
  import fpga_pkg::*;
#(
  parameter int DATA_W = SINK_DATA_W,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DATA_W:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [DATA_W:0] rd_data
);

  logic [DATA_W:0] mem [DEPTH];

  // Entry storage; contents carry no reset, validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/processed_data_sink.sv
// rtl/processed_data_sink.sv - FWFT buffer for processed words with error count and overflow; option SINK_ERR_DROP_EN
module processed_data_sink
  import fpga_pkg::*;
#(
  parameter int DATA_W   = SINK_DATA_W,
  parameter int DEPTH    = 16,
  parameter int ERRCNT_W = SINK_ERRCNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_error,
  input  logic                     flush,
  input  logic                     clr_status,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [ERRCNT_W-1:0]      err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  sink_state_t     state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [DATA_W:0] next_entry;
  logic            full;
  logic            running;
  logic            keep_word;
  logic            in_tag;
  logic            push;
  logic            pop;
  logic            drop;
  logic            err_evt;

`ifdef SINK_ERR_DROP_EN
  // Error words never enter the buffer, so every stored tag is zero.
  assign keep_word = !in_error;
  assign in_tag    = 1'b0;
`else
  assign keep_word = 1'b1;
  assign in_tag    = in_error;
`endif

  assign full    = (level == LW'(DEPTH));
  assign running = (state == RUN) && !flush;
  // full is judged before any same-cycle pop, so a word arriving at full is lost.
  assign push    = running && in_valid && keep_word && !full;
  assign drop    = running && in_valid && keep_word && full;
  assign pop     = running && out_valid && out_ready;
  assign err_evt = (state == RUN) && in_valid && in_error;

  // The array is read one entry past the head so the next word is ready when the head pops.
  sink_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_tag, in_data}),
    .rd_addr (rd_ptr + AW'(1)),
    .rd_data (next_entry)
  );

  // Pointer, level and registered head-of-queue tracking with the RUN/FLUSH sequencing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        RUN:     if (flush) state <= FLUSH;
        default: state <= RUN;
      endcase

      if (state == FLUSH || flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);

        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase

        if (pop) begin
          if (level > LW'(1)) begin
            {out_err, out_data} <= next_entry;
          end else if (push) begin
            // Last word leaves while a new one lands in the slot being read.
            {out_err, out_data} <= {in_tag, in_data};
          end else begin
            out_valid <= 1'b0;
          end
        end else if (push && level == '0) begin
          {out_err, out_data} <= {in_tag, in_data};
          out_valid           <= 1'b1;
        end
      end
    end
  end

  // Sticky overflow and saturating error count; a clear outranks a same-cycle event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else if (clr_status) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (err_evt && err_count != '1) err_count <= err_count + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_processed_data_sink.sv
// tb/tb_processed_data_sink.sv - randomized self-checking bench for processed_data_sink
module tb_processed_data_sink;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int ERRCNT_W = 8;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;
`ifdef SINK_ERR_DROP_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_error;
  logic                flush;
  logic                clr_status;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_err;
  logic [LW-1:0]       level;
  logic                overflow;
  logic [ERRCNT_W-1:0] err_count;

  processed_data_sink #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ERRCNT_W (ERRCNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_error   (in_error),
    .flush      (flush),
    .clr_status (clr_status),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .level      (level),
    .overflow   (overflow),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: a queue of {data, tag} words, a one-cycle flush shadow and the status values.
  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
  } word_t;

  word_t m_q[$];
  bit    m_in_flush;
  bit    m_ovf;
  int    m_cnt;

  task automatic model_step();
    bit was_full;
    bit had_word;
    bit accept;
    word_t w;
    if (!reset_n) begin
      m_q.delete();
      m_in_flush = 0;
      m_ovf      = 0;
      m_cnt      = 0;
      return;
    end
    if (m_in_flush) begin
      m_q.delete();
      m_in_flush = 0;
    end else begin
      if (in_valid && in_error && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        m_q.delete();
        m_in_flush = 1;
      end else begin
        was_full = (m_q.size() == DEPTH);
        had_word = (m_q.size() > 0);
        accept   = in_valid && !(DROP_ERR && in_error);
        if (had_word && out_ready) void'(m_q.pop_front());
        if (accept && !was_full) begin
          w.d = in_data;
          w.e = in_error;
          m_q.push_back(w);
        end
        if (accept && was_full) m_ovf = 1;
      end
    end
    if (clr_status) begin
      m_ovf = 0;
      m_cnt = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".level"}, 64'(level), 64'(m_q.size()));
    check({tag, ".valid"}, 64'(out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check({tag, ".data"}, 64'(out_data), 64'(m_q[0].d));
      check({tag, ".err"}, 64'(out_err), 64'(m_q[0].e));
    end
    check({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    check({tag, ".cnt"}, 64'(err_count), 64'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic e, input logic r);
    in_valid  = v;
    in_data   = d;
    in_error  = e;
    out_ready = r;
  endtask

  initial begin
    reset_n    = 1'b0;
    flush      = 1'b0;
    clr_status = 1'b0;
    drive(0, '0, 0, 0);
    @(negedge clk);
    cycle("rst");
    cycle("rst");
    check("rst.out_data", 64'(out_data), 64'd0);
    check("rst.out_err", 64'(out_err), 64'd0);
    reset_n = 1'b1;

    // Fill to capacity with the consumer stalled, then one more word.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'hA5A5A5A5 + i, 0, 0);
      cycle("fill");
    end
    check("fill.level16", 64'(level), 64'd16);
    check("fill.ovf0", 64'(overflow), 64'd0);
    drive(1, 32'h0BAD0BAD, 0, 0);
    cycle("over");
    check("over.level16", 64'(level), 64'd16);
    check("over.ovf1", 64'(overflow), 64'd1);

    // Drain one word per cycle in order.
    drive(0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.order", 64'(out_data), 64'(32'hA5A5A5A5 + i));
      cycle("drain");
    end
    check("drain.empty", 64'(out_valid), 64'd0);
    clr_status = 1'b1;
    drive(0, '0, 0, 0);
    cycle("clr");
    clr_status = 1'b0;

    // Tagged error word.
    drive(1, 32'hFFFFFF10, 1, 0);
    cycle("errw");
    check("errw.cnt", 64'(err_count), 64'd1);
    if (DROP_ERR) begin
      check("errw.absent", 64'(out_valid), 64'd0);
    end else begin
      check("errw.tag", 64'(out_err), 64'd1);
      check("errw.data", 64'(out_data), 64'hFFFFFF10);
    end
    drive(0, '0, 0, 1);
    cycle("errw.drain");

    // Hold level at 8 with simultaneous push and pop.
    for (int i = 0; i < 8; i++) begin
      drive(1, $urandom, 0, 0);
      cycle("half");
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, $urandom, 0, 1);
      cycle("steady");
    end
    check("steady.level8", 64'(level), 64'd8);
    drive(0, '0, 0, 1);
    for (int i = 0; i < 9; i++) cycle("steady.drain");

    // Error counter saturation and clear-wins.
    clr_status = 1'b1;
    drive(0, '0, 0, 1);
    cycle("sat.clr");
    clr_status = 1'b0;
    for (int i = 0; i < CNT_MAX - 1; i++) begin
      drive(1, $urandom, 1, 1);
      cycle("sat.ramp");
    end
    check("sat.near", 64'(err_count), 64'(CNT_MAX - 1));
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 1, 1);
      cycle("sat.top");
    end
    check("sat.max", 64'(err_count), 64'(CNT_MAX));
    clr_status = 1'b1;
    drive(1, $urandom, 1, 1);
    cycle("sat.clrwin");
    clr_status = 1'b0;
    check("sat.cleared", 64'(err_count), 64'd0);
    drive(0, '0, 0, 1);
    for (int i = 0; i < DEPTH + 1; i++) cycle("sat.drain");

    // Flush at level 5 with a same-cycle input.
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom, 0, 0);
      cycle("pre.flush");
    end
    check("flush.level5", 64'(level), 64'd5);
    flush = 1'b1;
    drive(1, 32'h12345678, 0, 0);
    cycle("flush");
    flush = 1'b0;
    check("flush.level0", 64'(level), 64'd0);
    check("flush.valid0", 64'(out_valid), 64'd0);
    drive(1, 32'h87654321, 0, 1);
    cycle("flush.ignore");
    check("flush.ignored", 64'(level), 64'd0);

    // Randomized traffic with occasional flush and clear.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
      flush      = ($urandom_range(0, 31) == 0);
      clr_status = ($urandom_range(0, 31) == 0);
      cycle("rand");
    end
    flush      = 1'b0;
    clr_status = 1'b0;

    // Reset in the middle of a drain.
    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom, 1, 0);
      cycle("mid.fill");
    end
    drive(0, '0, 0, 1);
    cycle("mid.drain");
    cycle("mid.drain");
    reset_n = 1'b0;
    cycle("mid.rst");
    check("mid.level", 64'(level), 64'd0);
    check("mid.valid", 64'(out_valid), 64'd0);
    check("mid.out_data", 64'(out_data), 64'd0);
    check("mid.out_err", 64'(out_err), 64'd0);
    check("mid.ovf", 64'(overflow), 64'd0);
    check("mid.cnt", 64'(err_count), 64'd0);
    reset_n = 1'b1;
    drive(0, '0, 0, 0);
    cycle("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
